// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the MEM-stage load/store unit.
//   - funct3 encodings for loads and stores
//   - lsu_state_t: LSU transaction FSM states
//   - f3_legal(): whether a funct3 is a defined load/store width
package rv32i_pkg;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
      logic ok;
      if (is_load)
         ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
              (f3 == F3_LBU) || (f3 == F3_LHU);
      else
         ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the LSU.
// Store side (live EX/MEM values):
//   is_load, funct3, addr_lo, data2 -> be, wdata, misaligned, illegal
// Load side (registered copies of the access being completed):
//   ld_funct3, ld_addr_lo, rdata    -> ld_data (shifted and extended)
module lsu_align
   import rv32i_pkg::*;
(
   input  logic        is_load,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] data2,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic        misaligned,
   output logic        illegal,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   // Store steering: replicate the datum across all lanes so the memory
   // only has to honour the byte enables.
   always_comb begin
      be    = 4'b1111;
      wdata = data2;
      case (funct3)
         F3_SB: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{data2[7:0]}};
         end
         F3_SH: begin
            be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata = {2{data2[15:0]}};
         end
         default: ;
      endcase
   end

   // funct3[1:0] encodes the width for both loads and stores.
   always_comb begin
      misaligned = 1'b0;
      case (funct3[1:0])
         2'b01:   misaligned = addr_lo[0];
         2'b10:   misaligned = (addr_lo != 2'b00);
         default: misaligned = 1'b0;
      endcase
   end

   assign illegal = !f3_legal(is_load, funct3);

   assign shifted = rdata >> {ld_addr_lo, 3'b000};

   always_comb begin
      ld_data = shifted;
      case (ld_funct3)
         F3_LB:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_LH:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_LBU:  ld_data = {24'b0, shifted[7:0]};
         F3_LHU:  ld_data = {16'b0, shifted[15:0]};
         default: ld_data = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit for the five-stage RV32I pipeline.
// Inputs : clk, rst_n (sync, active low), MEM_memRead, MEM_memWrite,
//          MEM_aluOut (byte address), MEM_data2 (store data), MEM_instr
//          (funct3 = [14:12]), dmem_ack, dmem_rdata.
// Outputs: dmem_req/we/addr/be/wdata (registered request, held to ack),
//          mem_stall (freeze upstream), load_data/load_valid (to MEM/WB),
//          access_fault (combinational, bad access in IDLE).
// One transaction: IDLE -> BUSY (wait for ack) -> DONE -> IDLE.
module mem_stage_lsu
   import rv32i_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MEM_memRead,
   input  logic        MEM_memWrite,
   input  logic [31:0] MEM_aluOut,
   input  logic [31:0] MEM_data2,
   input  logic [31:0] MEM_instr,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        mem_stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        access_fault
);

   lsu_state_t  state, next_state;
   logic [2:0]  funct3;
   logic        present, both, bad, start;
   logic [3:0]  st_be;
   logic [31:0] st_wdata, ld_data;
   logic        misaligned, illegal;
   logic [2:0]  r_f3;
   logic [1:0]  r_lo;
   logic        unused_ok;

   assign funct3    = MEM_instr[14:12];
   assign unused_ok = ^{MEM_instr[31:15], MEM_instr[11:0]};

   assign present = MEM_memRead ^ MEM_memWrite;
   assign both    = MEM_memRead & MEM_memWrite;
   assign bad     = illegal | misaligned;
   assign start   = (state == IDLE) & present & ~bad;

   // Faults are only meaningful while the instruction is first evaluated;
   // once in BUSY/DONE the registered copies drive everything.
   assign access_fault = (state == IDLE) & ((present & bad) | both);
   assign mem_stall    = start | (state == BUSY);

   lsu_align u_align (
      .is_load    (MEM_memRead),
      .funct3     (funct3),
      .addr_lo    (MEM_aluOut[1:0]),
      .data2      (MEM_data2),
      .be         (st_be),
      .wdata      (st_wdata),
      .misaligned (misaligned),
      .illegal    (illegal),
      .ld_funct3  (r_f3),
      .ld_addr_lo (r_lo),
      .rdata      (dmem_rdata),
      .ld_data    (ld_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = BUSY;
         BUSY:    if (dmem_ack) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_be    <= '0;
         dmem_wdata <= '0;
         load_data  <= '0;
         load_valid <= 1'b0;
         r_f3       <= '0;
         r_lo       <= '0;
      end else begin
         load_valid <= 1'b0;
         case (state)
            IDLE: if (start) begin
               dmem_req   <= 1'b1;
               dmem_we    <= MEM_memWrite;
               dmem_addr  <= {MEM_aluOut[31:2], 2'b00};
               dmem_be    <= MEM_memRead ? 4'b1111 : st_be;
               dmem_wdata <= MEM_memRead ? 32'h0 : st_wdata;
               r_f3       <= funct3;
               r_lo       <= MEM_aluOut[1:0];
            end
            BUSY: if (dmem_ack) begin
               dmem_req <= 1'b0;
               if (!dmem_we) begin
                  load_data  <= ld_data;
                  load_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
